// File: rtl/mem_issue_queue_if.sv
// Bundle connecting mem_issue_queue to dispatch, writeback wakeup and the AGU.
// The queue is the slave; the surrounding pipeline (or bench) is the master.
interface mem_issue_queue_if #(
    parameter int DEPTH     = 8,
    parameter int PREG_W    = 6,
    parameter int PAYLOAD_W = 64
);
    localparam int OCC_W = $clog2(DEPTH) + 1;

    // valid/ready: a transfer happens on a rising clk edge where both are high;
    // the offering side holds its data stable while valid is high and ready low.
    logic                 flush;
    logic                 dispatch_valid;
    logic                 dispatch_ready;
    logic [PREG_W-1:0]    dispatch_src1_preg;
    logic                 dispatch_src1_rdy;
    logic [PREG_W-1:0]    dispatch_src2_preg;
    logic                 dispatch_src2_rdy;
    logic [PAYLOAD_W-1:0] dispatch_payload;
    logic                 wakeup0_valid;
    logic [PREG_W-1:0]    wakeup0_preg;
    logic                 wakeup1_valid;
    logic [PREG_W-1:0]    wakeup1_preg;
    logic                 issue_valid;
    logic                 agu_allowin;
    logic [PREG_W-1:0]    issue_src1_preg;
    logic [PREG_W-1:0]    issue_src2_preg;
    logic [PAYLOAD_W-1:0] issue_payload;
    logic [OCC_W-1:0]     occupancy;

    modport master (
        output flush, dispatch_valid, dispatch_src1_preg, dispatch_src1_rdy,
               dispatch_src2_preg, dispatch_src2_rdy, dispatch_payload,
               wakeup0_valid, wakeup0_preg, wakeup1_valid, wakeup1_preg, agu_allowin,
        input  dispatch_ready, issue_valid, issue_src1_preg, issue_src2_preg,
               issue_payload, occupancy
    );

    modport slave (
        input  flush, dispatch_valid, dispatch_src1_preg, dispatch_src1_rdy,
               dispatch_src2_preg, dispatch_src2_rdy, dispatch_payload,
               wakeup0_valid, wakeup0_preg, wakeup1_valid, wakeup1_preg, agu_allowin,
        output dispatch_ready, issue_valid, issue_src1_preg, issue_src2_preg,
               issue_payload, occupancy
    );
endinterface

// File: rtl/mem_issue_queue.sv
// In-order load/store issue queue with two-port wakeup; only the head may issue.
// Optional same-cycle bypass into the AGU when empty: define MEMQ_BYPASS_EN.
module mem_issue_queue #(
    parameter int DEPTH     = 8,
    parameter int PREG_W    = 6,
    parameter int PAYLOAD_W = 64
) (
    input logic clk,
    input logic reset,
    mem_issue_queue_if.slave q
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    logic [PREG_W-1:0]    src1_q [DEPTH];
    logic [PREG_W-1:0]    src1_d [DEPTH];
    logic [PREG_W-1:0]    src2_q [DEPTH];
    logic [PREG_W-1:0]    src2_d [DEPTH];
    logic [PAYLOAD_W-1:0] pl_q   [DEPTH];
    logic [PAYLOAD_W-1:0] pl_d   [DEPTH];
    logic [DEPTH-1:0]     rdy1_q, rdy1_d, rdy2_q, rdy2_d;
    logic [PTR_W-1:0]     head_q, head_d, tail_q, tail_d;
    logic [OCC_W-1:0]     occ_q, occ_d;

    logic disp_rdy1, disp_rdy2, head_ready, bypass, disp_fire, push, pop;

    function automatic logic woke(input logic [PREG_W-1:0] tag,
                                  input logic w0v, input logic [PREG_W-1:0] w0p,
                                  input logic w1v, input logic [PREG_W-1:0] w1p);
        return (w0v && (w0p == tag)) || (w1v && (w1p == tag));
    endfunction

    always_comb begin
        // Tag 0 is the zero register and never waits.
        disp_rdy1 = (q.dispatch_src1_preg == '0) || q.dispatch_src1_rdy ||
                    woke(q.dispatch_src1_preg, q.wakeup0_valid, q.wakeup0_preg,
                         q.wakeup1_valid, q.wakeup1_preg);
        disp_rdy2 = (q.dispatch_src2_preg == '0) || q.dispatch_src2_rdy ||
                    woke(q.dispatch_src2_preg, q.wakeup0_valid, q.wakeup0_preg,
                         q.wakeup1_valid, q.wakeup1_preg);
        head_ready = (occ_q != '0) && rdy1_q[head_q] && rdy2_q[head_q];

        q.dispatch_ready  = occ_q < OCC_W'(DEPTH);
        q.occupancy       = occ_q;
        q.issue_valid     = head_ready;
        q.issue_src1_preg = (occ_q != '0) ? src1_q[head_q] : '0;
        q.issue_src2_preg = (occ_q != '0) ? src2_q[head_q] : '0;
        q.issue_payload   = (occ_q != '0) ? pl_q[head_q]   : '0;
        bypass            = 1'b0;
`ifdef MEMQ_BYPASS_EN
        if ((occ_q == '0) && q.dispatch_valid && disp_rdy1 && disp_rdy2 &&
            !q.flush && !reset) begin
            bypass            = 1'b1;
            q.issue_valid     = 1'b1;
            q.issue_src1_preg = q.dispatch_src1_preg;
            q.issue_src2_preg = q.dispatch_src2_preg;
            q.issue_payload   = q.dispatch_payload;
        end
`endif
        disp_fire = q.dispatch_valid && q.dispatch_ready;
        pop       = head_ready && q.agu_allowin;
        // A bypassed op that the AGU takes never occupies a slot.
        push      = disp_fire && !(bypass && q.agu_allowin);
    end

    always_comb begin
        src1_d = src1_q;
        src2_d = src2_q;
        pl_d   = pl_q;
        rdy1_d = rdy1_q;
        rdy2_d = rdy2_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (woke(src1_q[i], q.wakeup0_valid, q.wakeup0_preg, q.wakeup1_valid, q.wakeup1_preg))
                rdy1_d[i] = 1'b1;
            if (woke(src2_q[i], q.wakeup0_valid, q.wakeup0_preg, q.wakeup1_valid, q.wakeup1_preg))
                rdy2_d[i] = 1'b1;
        end
        if (push) begin
            src1_d[tail_q] = q.dispatch_src1_preg;
            src2_d[tail_q] = q.dispatch_src2_preg;
            pl_d[tail_q]   = q.dispatch_payload;
            rdy1_d[tail_q] = disp_rdy1;
            rdy2_d[tail_q] = disp_rdy2;
        end

        head_d = head_q + PTR_W'(pop);
        tail_d = tail_q + PTR_W'(push);
        occ_d  = occ_q + OCC_W'(push) - OCC_W'(pop);
        if (q.flush) begin
            head_d = '0;
            tail_d = '0;
            occ_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
        end
    end

    // Entry contents need no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        src1_q <= src1_d;
        src2_q <= src2_d;
        pl_q   <= pl_d;
        rdy1_q <= rdy1_d;
        rdy2_q <= rdy2_d;
    end
endmodule

// File: tb/tb_mem_issue_queue.sv
// Directed plus random bench for mem_issue_queue against a queue-based model.
module tb_mem_issue_queue;
    localparam int DEPTH = 8;
    localparam int PREG_W = 6;
    localparam int PAYLOAD_W = 64;

    typedef struct {
        logic [PREG_W-1:0]    s1;
        logic [PREG_W-1:0]    s2;
        bit                   r1;
        bit                   r2;
        logic [PAYLOAD_W-1:0] pl;
    } ent_t;

    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    ent_t mq[$];
    logic [PAYLOAD_W-1:0] obs_iss[$];

    mem_issue_queue_if #(.DEPTH(DEPTH), .PREG_W(PREG_W), .PAYLOAD_W(PAYLOAD_W)) bus ();

    mem_issue_queue #(.DEPTH(DEPTH), .PREG_W(PREG_W), .PAYLOAD_W(PAYLOAD_W)) dut (
        .clk(clk), .reset(reset), .q(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit wk(input logic [PREG_W-1:0] t);
        return (bus.wakeup0_valid && bus.wakeup0_preg == t) ||
               (bus.wakeup1_valid && bus.wakeup1_preg == t);
    endfunction

    task automatic idle();
        bus.flush = 0; bus.dispatch_valid = 0;
        bus.dispatch_src1_preg = 0; bus.dispatch_src1_rdy = 0;
        bus.dispatch_src2_preg = 0; bus.dispatch_src2_rdy = 0;
        bus.dispatch_payload = 0;
        bus.wakeup0_valid = 0; bus.wakeup0_preg = 0;
        bus.wakeup1_valid = 0; bus.wakeup1_preg = 0;
        reset = 0;
    endtask

    task automatic disp(input int s1, input bit r1, input int s2, input bit r2,
                        input logic [63:0] pl);
        bus.dispatch_valid = 1;
        bus.dispatch_src1_preg = PREG_W'(s1); bus.dispatch_src1_rdy = r1;
        bus.dispatch_src2_preg = PREG_W'(s2); bus.dispatch_src2_rdy = r2;
        bus.dispatch_payload = pl;
    endtask

    // One clock: check outputs against the model, then advance the model.
    task automatic tick();
        ent_t e;
        int   sz;
        bit   exp_rdy, exp_iv, byp, fire_i, fire_d;
        logic [PREG_W-1:0] exp_s1, exp_s2;
        logic [PAYLOAD_W-1:0] exp_pl;
        #1;
        sz = mq.size();
        e.s1 = bus.dispatch_src1_preg; e.s2 = bus.dispatch_src2_preg;
        e.r1 = (e.s1 == 0) || bus.dispatch_src1_rdy || wk(e.s1);
        e.r2 = (e.s2 == 0) || bus.dispatch_src2_rdy || wk(e.s2);
        e.pl = bus.dispatch_payload;
        exp_rdy = sz < DEPTH;
        exp_iv  = (sz > 0) && mq[0].r1 && mq[0].r2;
        exp_s1  = (sz > 0) ? mq[0].s1 : '0;
        exp_s2  = (sz > 0) ? mq[0].s2 : '0;
        exp_pl  = (sz > 0) ? mq[0].pl : '0;
        byp = 0;
`ifdef MEMQ_BYPASS_EN
        if (sz == 0 && bus.dispatch_valid && e.r1 && e.r2 && !bus.flush && !reset) begin
            byp = 1; exp_iv = 1; exp_s1 = e.s1; exp_s2 = e.s2; exp_pl = e.pl;
        end
`endif
        chk("dispatch_ready", 64'(bus.dispatch_ready), 64'(exp_rdy));
        chk("occupancy", 64'(bus.occupancy), 64'(sz));
        chk("issue_valid", 64'(bus.issue_valid), 64'(exp_iv));
        chk("issue_src1_preg", 64'(bus.issue_src1_preg), 64'(exp_s1));
        chk("issue_src2_preg", 64'(bus.issue_src2_preg), 64'(exp_s2));
        chk("issue_payload", 64'(bus.issue_payload), 64'(exp_pl));
        if (bus.issue_valid && bus.agu_allowin && !reset && !bus.flush)
            obs_iss.push_back(bus.issue_payload);
        fire_i = exp_iv && bus.agu_allowin;
        fire_d = bus.dispatch_valid && exp_rdy;
        @(posedge clk);
        if (reset || bus.flush) begin
            mq.delete();
        end else begin
            if (fire_i && !byp) void'(mq.pop_front());
            foreach (mq[i]) begin
                if (wk(mq[i].s1)) mq[i].r1 = 1;
                if (wk(mq[i].s2)) mq[i].r2 = 1;
            end
            if (fire_d && !(byp && fire_i)) mq.push_back(e);
        end
        #1;
    endtask

    initial begin
        idle();
        bus.agu_allowin = 0;
        reset = 1;
        @(posedge clk); #1;
        tick(); tick();
        reset = 0;
        tick();
        chk("rst_occupancy", 64'(bus.occupancy), 64'd0);
        chk("rst_ready", 64'(bus.dispatch_ready), 64'd1);
        chk("rst_issue_valid", 64'(bus.issue_valid), 64'd0);

        // Single ready op flows straight through.
        bus.agu_allowin = 1;
        disp(5, 1, 0, 0, 64'hA);
        tick(); idle(); tick(); tick();
        chk("first_payload", obs_iss.size() > 0 ? obs_iss[$] : 64'hDEAD, 64'hA);
        chk("first_occ_empty", 64'(bus.occupancy), 64'd0);

        // Blocked head keeps a ready younger op waiting.
        obs_iss.delete();
        disp(7, 0, 3, 1, 64'hA0); tick();
        disp(1, 1, 2, 1, 64'hB0); tick();
        idle(); tick(); tick();
        chk("blocked_no_issue", 64'(obs_iss.size()), 64'd0);
        bus.wakeup1_valid = 1; bus.wakeup1_preg = 7; tick();
        idle(); tick(); tick(); tick();
        chk("order_count", 64'(obs_iss.size()), 64'd2);
        if (obs_iss.size() == 2) begin
            chk("order_a", obs_iss[0], 64'hA0);
            chk("order_b", obs_iss[1], 64'hB0);
        end

        // Fill to full, refuse a ninth, free one slot.
        bus.agu_allowin = 0;
        for (int i = 0; i < DEPTH; i++) begin
            disp(i + 1, 1, 0, 1, 64'(64'h200 + i)); tick();
        end
        chk("full_occ", 64'(bus.occupancy), 64'(DEPTH));
        chk("full_ready", 64'(bus.dispatch_ready), 64'd0);
        disp(3, 1, 3, 1, 64'h2FF); tick();
        chk("refused_occ", 64'(bus.occupancy), 64'(DEPTH));
        idle(); bus.agu_allowin = 1; tick();
        bus.agu_allowin = 0; tick();
        chk("freed_ready", 64'(bus.dispatch_ready), 64'd1);
        bus.agu_allowin = 1;
        for (int i = 0; i < DEPTH; i++) tick();

        // Same-cycle wakeup captured at dispatch.
        disp(0, 0, 9, 0, 64'h99);
        bus.wakeup0_valid = 1; bus.wakeup0_preg = 9;
        tick(); idle(); tick(); tick();
        chk("wake_at_dispatch_occ", 64'(bus.occupancy), 64'd0);

        // Flush beats same-cycle dispatch.
        bus.agu_allowin = 0;
        for (int i = 0; i < 5; i++) begin
            disp(i + 1, 1, 1, 1, 64'(64'h300 + i)); tick();
        end
        disp(4, 1, 4, 1, 64'h3FF); bus.flush = 1; tick();
        chk("flush_occ", 64'(bus.occupancy), 64'd0);
        chk("flush_issue_valid", 64'(bus.issue_valid), 64'd0);
        idle(); tick();

        // Back-to-back streaming across two pointer wraps.
        obs_iss.delete();
        bus.agu_allowin = 1;
        for (int i = 0; i < 20; i++) begin
            disp(2, 1, 3, 1, 64'(64'h100 + i)); tick();
            chk("stream_occ_le1", 64'(bus.occupancy <= 1), 64'd1);
        end
        idle(); tick(); tick();
        chk("stream_count", 64'(obs_iss.size()), 64'd20);
        for (int i = 0; i < 20 && i < obs_iss.size(); i++)
            chk("stream_order", obs_iss[i], 64'(64'h100 + i));

        // Random traffic, including flush and mid-run reset.
        for (int n = 0; n < 600; n++) begin
            idle();
            if ($urandom_range(0, 99) < 60)
                disp($urandom_range(0, 7), 1'($urandom_range(0, 1)), $urandom_range(0, 7),
                     1'($urandom_range(0, 1)), {$urandom, $urandom});
            bus.wakeup0_valid = 1'($urandom_range(0, 1));
            bus.wakeup0_preg  = PREG_W'($urandom_range(0, 7));
            bus.wakeup1_valid = ($urandom_range(0, 3) == 0);
            bus.wakeup1_preg  = PREG_W'($urandom_range(0, 7));
            bus.agu_allowin   = ($urandom_range(0, 9) < 6);
            bus.flush         = ($urandom_range(0, 99) < 2);
            reset             = ($urandom_range(0, 199) == 0);
            tick();
        end
        idle();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
